cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares the `N` common-data-bus lanes among all functional-unit result ports (adders, multipliers, branch units, memory ports). Each cycle it grants up to `N` pending results in round-robin order, registers them onto `cdb_output`, and back-pressures ungranted units so they hold their result. It sits between the functional-unit outputs and the CDB consumers (ROB, RS wakeup, map table).

## Interface
- `N`, 4: CDB lanes; superscalar width.
- `NUM_REQ`, 16: requesting result ports, ordered adders[0..3], mults[0..3], branches[0..3], mems[0..3].
- `PRF_BITS`, 6: physical register tag width.
- `XLEN`, 32: result value width.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `nuke`  in  1: mispredict flush; synchronous.
- `req_valid`  in  `NUM_REQ`: port i holds a finished result.
- `req_dest_prf`  in  `NUM_REQ`×`PRF_BITS`: destination tag per port.
- `req_value`  in  `NUM_REQ`×`XLEN`: result per port.
- `req_grant`  out  `NUM_REQ`: combinational; port i's result is taken at this edge.
- `cdb_output`  out  `N`×CDB: registered lanes of {valid, dest_prf, value}.
- `num_granted`  out  `$clog2(N+1)`: combinational count of grants this cycle.

## Operation
- Round-robin pointer `rr_ptr`, `$clog2(NUM_REQ)` bits. Scan order: rr_ptr, rr_ptr+1, …, mod `NUM_REQ`.
- Requests are granted in scan order until `N` grants are issued or the scan ends.
- The k-th grant in scan order (k = 0..N-1) goes to lane k. Lanes with no grant latch valid=0 with dest_prf=0 and value=0.
- `req_grant[i]` is combinational from `req_valid` and `rr_ptr`. A granted port drops or replaces its result next cycle.
- An ungranted port with `req_valid=1` holds its valid, tag and value stable until granted. This is a requester obligation, and the bench asserts it.
- Pointer update when at least one grant is issued: rr_ptr ← (index of last granted port + 1) mod `NUM_REQ`. With zero grants, rr_ptr is unchanged.
- Fairness: a continuously valid port is granted within ⌈NUM_REQ/N⌉ cycles.
- `nuke=1`:
  - All `req_grant` are forced to 0 that cycle.
  - Every `cdb_output` lane latches valid=0 at the edge.
  - rr_ptr ← 0.
  - In-flight FU results are discarded by the FUs themselves.
- `reset=1`: same effect as nuke, and it takes priority over nuke.
- The arbiter performs no arithmetic on values; tags and values pass through unchanged.

## Timing
- Reset values: all `cdb_output` fields 0; rr_ptr=0. `req_grant`=0 and `num_granted`=0 while reset is high.
- Latency: a result granted in cycle t appears on `cdb_output` during cycle t+1, one registered stage.
- Throughput: N results/cycle when at least N requests are pending.
- Fewer than N requests: all are granted in the same cycle and packed into the low lanes.
- Exactly N requests: all granted. rr_ptr lands one past the last granted port, which may wrap to 0.
- Wrap-around: with rr_ptr=14 and requests at 15, 0 and 1, lane0←15, lane1←0, lane2←1, and rr_ptr←2.
- `nuke` and requests in the same cycle: no grants, and the next cycle's CDB is empty.
- `reset` deasserting mid-stream: the first cycle after reset arbitrates normally from rr_ptr=0.

## Structure
- Shared package holds:
  - the CDB typedef {valid, dest_prf, value}.
  - the `N`, `XLEN`, `PRF_BITS` defines.
  - the functional-unit port-index constants (ADDER_BASE=0, MULT_BASE=4, BRANCH_BASE=8, MEM_BASE=12).
- One sub-module, `rr_multi_select`. It is combinational and maps (request vector, pointer) to a grant vector plus a per-lane port index, returning up to `N` picks in rotated priority order.
- The parent holds rr_ptr, the output register, and the nuke/reset handling.

## Test plan
- Reset, then a single request on port 0 with tag 0x1 and value 0x4 → grant[0] same cycle; next cycle lane0 = {1, 0x1, 0x4}, lanes 1–3 invalid, rr_ptr=1.
- Requests on all 16 ports held continuously → grants 0–3, then 4–7, 8–11, 12–15, 0–3. Every port is served within 4 cycles and each cycle shows 4 valid lanes.
- rr_ptr=14 with requests on ports 15, 0 and 1 → lanes 0/1/2 carry ports 15/0/1, lane3 invalid, rr_ptr=2.
- Ports 4 and 9 stay valid while ungranted, behind 4 higher-priority ports → each is granted no later than the following cycle, and its tag/value are unchanged on the CDB.
- `nuke` asserted with 6 pending requests → zero grants that cycle, all lanes invalid next cycle, rr_ptr=0; the following cycle grants ports 0–3.
- `reset` asserted mid-stream with valid lanes on the CDB → next cycle all lanes read 0 and no grants are issued while reset is high.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB lane format, arbiter sizing and functional-unit port map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

  localparam int N        = 4;
  localparam int NUM_REQ  = 16;
  localparam int PRF_BITS = 6;
  localparam int XLEN     = 32;

  localparam int PTR_BITS  = $clog2(NUM_REQ);
  localparam int CNT_BITS  = $clog2(N + 1);
  localparam int LANE_BITS = $clog2(N);

  // Requesting port layout: four of each functional-unit kind.
  localparam int ADDER_BASE  = 0;
  localparam int MULT_BASE   = 4;
  localparam int BRANCH_BASE = 8;
  localparam int MEM_BASE    = 12;

  // One CDB lane; valid sits in the MSB of the packed lane.
  typedef struct packed {
    logic                valid;
    logic [PRF_BITS-1:0] dest_prf;
    logic [XLEN-1:0]     value;
  } cdb_t;

  localparam int CDB_W = $bits(cdb_t);

  // Advance a port index by one, wrapping at NUM_REQ.
  function automatic logic [PTR_BITS-1:0] wrap_inc(input logic [PTR_BITS-1:0] idx);
    logic [PTR_BITS-1:0] r;
    if (idx == PTR_BITS'(NUM_REQ - 1)) r = '0;
    else                               r = idx + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_select.sv
// Picks up to N requests in rotated priority order starting at ptr.
// Latency: purely combinational.
// Backpressure: ungranted requests simply see grant=0 and must hold.
module rr_multi_select
  import cdb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]              req,
  input  logic [PTR_BITS-1:0]             ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic [N-1:0]                    lane_vld,
  output logic [N-1:0][PTR_BITS-1:0]      lane_idx,
  output logic [CNT_BITS-1:0]             count,
  output logic [PTR_BITS-1:0]             last_idx
);

  localparam logic [PTR_BITS:0]   NUM_REQ_W = (PTR_BITS + 1)'(NUM_REQ);
  localparam logic [CNT_BITS-1:0] N_CNT     = CNT_BITS'(N);

  // Scan position, one bit wider so the wrap can be detected.
  logic [PTR_BITS:0] pos;

  // Walk ports from ptr onward, handing the k-th hit to lane k until lanes run out.
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    lane_idx = '0;
    count    = '0;
    last_idx = '0;
    pos      = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      pos = {1'b0, ptr} + (PTR_BITS + 1)'(s);
      if (pos >= NUM_REQ_W) pos = pos - NUM_REQ_W;
      if (req[pos[PTR_BITS-1:0]] && (count < N_CNT)) begin
        grant[pos[PTR_BITS-1:0]]           = 1'b1;
        lane_vld[count[LANE_BITS-1:0]]     = 1'b1;
        lane_idx[count[LANE_BITS-1:0]]     = pos[PTR_BITS-1:0];
        last_idx                           = pos[PTR_BITS-1:0];
        count                              = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to N functional-unit results per cycle onto the CDB, round-robin.
// Latency: grant is combinational; granted result is on cdb_output one cycle later.
// Backpressure: ungranted ports keep req_valid high and hold tag/value until granted.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        nuke,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*PRF_BITS-1:0] req_dest_prf,
  input  logic [NUM_REQ*XLEN-1:0]     req_value,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [N*CDB_W-1:0]          cdb_output,
  output logic [CNT_BITS-1:0]         num_granted
);

  logic                         flush;
  logic [NUM_REQ-1:0]           req_eff;
  logic [PTR_BITS-1:0]          rr_ptr;
  logic [N-1:0]                 lane_vld;
  logic [N-1:0][PTR_BITS-1:0]   lane_idx;
  logic [CNT_BITS-1:0]          sel_count;
  logic [PTR_BITS-1:0]          last_idx;
  cdb_t [N-1:0]                 cdb_nxt;
  cdb_t [N-1:0]                 cdb_q;

  // Reset and nuke both suppress every grant, so requests are masked before selection.
  assign flush   = reset | nuke;
  assign req_eff = flush ? '0 : req_valid;

  rr_multi_select u_sel (
    .req      (req_eff),
    .ptr      (rr_ptr),
    .grant    (req_grant),
    .lane_vld (lane_vld),
    .lane_idx (lane_idx),
    .count    (sel_count),
    .last_idx (last_idx)
  );

  assign num_granted = sel_count;
  assign cdb_output  = cdb_q;

  // Route each selected port's tag and value into its lane; empty lanes stay all-zero.
  always_comb begin
    cdb_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (lane_vld[k]) begin
        cdb_nxt[k].valid    = 1'b1;
        cdb_nxt[k].dest_prf = req_dest_prf[lane_idx[k]*PRF_BITS +: PRF_BITS];
        cdb_nxt[k].value    = req_value[lane_idx[k]*XLEN +: XLEN];
      end
    end
  end

  // Register the lanes and move the pointer one past the last winner.
  always_ff @(posedge clock) begin
    if (flush) begin
      cdb_q  <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_q <= cdb_nxt;
      if (sel_count != '0) rr_ptr <= wrap_inc(last_idx);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed corner cases plus random traffic.
// Latency: expects lane data one cycle after grant.
// Backpressure: stimulus honours the hold-until-granted requester rule.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        nuke;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*PRF_BITS-1:0] req_dest_prf;
  logic [NUM_REQ*XLEN-1:0]     req_value;
  logic [NUM_REQ-1:0]          req_grant;
  logic [N*CDB_W-1:0]          cdb_output;
  logic [CNT_BITS-1:0]         num_granted;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .nuke         (nuke),
    .req_valid    (req_valid),
    .req_dest_prf (req_dest_prf),
    .req_value    (req_value),
    .req_grant    (req_grant),
    .cdb_output   (cdb_output),
    .num_granted  (num_granted)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int                 ptr_m = 0;
  logic [NUM_REQ-1:0] m_grant;
  int                 m_cnt;
  int                 m_lane[N];
  logic [N*CDB_W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [CDB_W-1:0] lane_of(input logic [N*CDB_W-1:0] v, input int k);
    return v[k*CDB_W +: CDB_W];
  endfunction

  function automatic logic [CDB_W-1:0] mk(input logic v, input logic [PRF_BITS-1:0] t,
                                          input logic [XLEN-1:0] d);
    return {v, t, d};
  endfunction

  function automatic logic [PRF_BITS-1:0] tag_of(input int p);
    return PRF_BITS'(p + 16);
  endfunction

  function automatic logic [XLEN-1:0] val_of(input int p);
    return 32'hC0DE_0000 + XLEN'(p);
  endfunction

  task automatic set_port(input int p, input logic [PRF_BITS-1:0] t, input logic [XLEN-1:0] d);
    req_valid[p]                        = 1'b1;
    req_dest_prf[p*PRF_BITS +: PRF_BITS] = t;
    req_value[p*XLEN +: XLEN]            = d;
  endtask

  // Reference arbitration: rotated scan, first N requesters win in order.
  task automatic model_arb(input logic blk);
    int p;
    m_grant = '0;
    m_cnt   = 0;
    for (int k = 0; k < N; k++) m_lane[k] = -1;
    if (!blk) begin
      for (int s = 0; s < NUM_REQ; s++) begin
        p = (ptr_m + s) % NUM_REQ;
        if (req_valid[p] && m_cnt < N) begin
          m_grant[p]    = 1'b1;
          m_lane[m_cnt] = p;
          m_cnt++;
        end
      end
    end
  endtask

  // One clock: check combinational grant, queue expected lanes, then compare after the edge.
  task automatic cycle(input int exp_g = -1);
    logic [N*CDB_W-1:0] exp_v;
    logic [N*CDB_W-1:0] got_v;
    int p;
    #2;
    model_arb(reset | nuke);
    chk("grant", req_grant, m_grant);
    chk("num_granted", num_granted, m_cnt);
    if (exp_g >= 0) chk("dir_grant", req_grant, exp_g);
    exp_v = '0;
    for (int k = 0; k < N; k++) begin
      if (m_lane[k] >= 0) begin
        p = m_lane[k];
        exp_v[k*CDB_W +: CDB_W] = mk(1'b1, req_dest_prf[p*PRF_BITS +: PRF_BITS],
                                     req_value[p*XLEN +: XLEN]);
      end
    end
    sb_q.push_back(exp_v);
    if (reset || nuke)  ptr_m = 0;
    else if (m_cnt > 0) ptr_m = (m_lane[m_cnt-1] + 1) % NUM_REQ;
    @(posedge clock);
    #1;
    got_v = cdb_output;
    exp_v = sb_q.pop_front();
    for (int k = 0; k < N; k++)
      chk($sformatf("lane%0d", k), lane_of(got_v, k), lane_of(exp_v, k));
    chk("rr_ptr", dut.rr_ptr, ptr_m);
  endtask

  function automatic int count_valid(input logic [N*CDB_W-1:0] v);
    int c = 0;
    for (int k = 0; k < N; k++) c += int'(v[k*CDB_W + CDB_W - 1]);
    return c;
  endfunction

  logic [NUM_REQ-1:0]          prv_v;
  logic [NUM_REQ-1:0]          prv_g;
  logic                        prv_flush;
  logic [NUM_REQ*PRF_BITS-1:0] prv_t;
  logic [NUM_REQ*XLEN-1:0]     prv_d;

  initial begin
    reset        = 1'b1;
    nuke         = 1'b0;
    req_valid    = '0;
    req_dest_prf = '0;
    req_value    = '0;

    // Reset: requests present but nothing granted, CDB and pointer at zero.
    for (int p = 0; p < NUM_REQ; p++) set_port(p, tag_of(p), val_of(p));
    cycle(0);
    cycle(0);
    chk("rst_cdb", cdb_output == '0, 1'b1);
    chk("rst_ptr", dut.rr_ptr, 0);

    // Single request on port 0.
    reset     = 1'b0;
    req_valid = '0;
    set_port(0, 6'h1, 32'h4);
    cycle(16'h0001);
    chk("single_lane0", lane_of(cdb_output, 0), mk(1'b1, 6'h1, 32'h4));
    chk("single_nvalid", count_valid(cdb_output), 1);
    chk("single_ptr", dut.rr_ptr, 1);

    // Idle nuke to bring the pointer home.
    req_valid = '0;
    nuke      = 1'b1;
    cycle(0);
    nuke = 1'b0;

    // All ports held: groups of four rotate, full lanes every cycle.
    for (int p = 0; p < NUM_REQ; p++) set_port(p, tag_of(p), val_of(p));
    for (int c = 0; c < 5; c++) begin
      cycle(32'h000F << (4 * (c % 4)));
      chk("full_nvalid", count_valid(cdb_output), N);
    end

    // Walk pointer to 14, then wrap-around case.
    req_valid = '0;
    set_port(13, tag_of(13), val_of(13));
    cycle(1 << 13);
    chk("ptr14", dut.rr_ptr, 14);
    req_valid = '0;
    set_port(15, tag_of(15), val_of(15));
    set_port(0, tag_of(0), val_of(0));
    set_port(1, tag_of(1), val_of(1));
    cycle(16'h8003);
    chk("wrap_lane0", lane_of(cdb_output, 0), mk(1'b1, tag_of(15), val_of(15)));
    chk("wrap_lane1", lane_of(cdb_output, 1), mk(1'b1, tag_of(0), val_of(0)));
    chk("wrap_lane2", lane_of(cdb_output, 2), mk(1'b1, tag_of(1), val_of(1)));
    chk("wrap_lane3", lane_of(cdb_output, 3), '0);
    chk("wrap_ptr", dut.rr_ptr, 2);

    // Ports 4 and 9 wait behind 0..3, then go through untouched.
    req_valid = '0;
    nuke      = 1'b1;
    cycle(0);
    nuke = 1'b0;
    for (int p = 0; p < 5; p++) set_port(p, tag_of(p), val_of(p));
    set_port(9, 6'h2A, 32'hDEAD_BEEF);
    cycle(16'h000F);
    req_valid[3:0] = '0;
    cycle(16'h0210);
    chk("hold_p4", lane_of(cdb_output, 0), mk(1'b1, tag_of(4), val_of(4)));
    chk("hold_p9", lane_of(cdb_output, 1), mk(1'b1, 6'h2A, 32'hDEAD_BEEF));
    chk("hold_ptr", dut.rr_ptr, 10);

    // Nuke with six pending requests.
    req_valid = '0;
    for (int p = 0; p < 6; p++) set_port(p, tag_of(p), val_of(p));
    nuke = 1'b1;
    cycle(0);
    nuke = 1'b0;
    chk("nuke_cdb", cdb_output == '0, 1'b1);
    chk("nuke_ptr", dut.rr_ptr, 0);
    cycle(16'h000F);

    // Reset mid-stream with valid lanes on the bus.
    chk("prereset_valid", count_valid(cdb_output), N);
    req_valid[3:0] = '0;
    reset = 1'b1;
    cycle(0);
    chk("midrst_cdb", cdb_output == '0, 1'b1);
    cycle(0);
    reset = 1'b0;
    cycle(16'h0030);

    // Random traffic with hold-until-granted requesters and occasional nukes.
    model_arb(1'b1);
    prv_flush = 1'b1;
    for (int c = 0; c < 300; c++) begin
      prv_v = req_valid;
      prv_t = req_dest_prf;
      prv_d = req_value;
      for (int p = 0; p < NUM_REQ; p++) begin
        if (prv_flush) begin
          req_valid[p] = 1'b0;
        end else if (!req_valid[p] || m_grant[p]) begin
          if ($urandom_range(0, 9) < 6) set_port(p, PRF_BITS'($urandom), $urandom);
          else                          req_valid[p] = 1'b0;
        end
      end
      for (int p = 0; p < NUM_REQ; p++) begin
        if (prv_v[p] && !prv_g[p] && !prv_flush)
          assert (req_valid[p] && req_dest_prf[p*PRF_BITS +: PRF_BITS] == prv_t[p*PRF_BITS +: PRF_BITS]
                  && req_value[p*XLEN +: XLEN] == prv_d[p*XLEN +: XLEN])
          else $error("requester hold broken on port %0d", p);
      end
      nuke = ($urandom_range(0, 19) == 0);
      cycle();
      prv_g     = m_grant;
      prv_flush = nuke;
      if (c == 0) prv_g = m_grant;
    end
    nuke = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
